// File: rtl/c_fetch_align.sv
// rtl/c_fetch_align.sv - instruction fetch aligner for mixed 16/32-bit parcels
module c_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_comp_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  typedef enum logic {
    RUN     = 1'b0,
    SKIP_HI = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hb_q [4];
  logic [15:0] hb_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_q, fetch_d;

  logic        head32;
  logic        push;
  logic        pop;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  surv;
  logic [2:0]  src;

  assign head32       = (hb_q[0][1:0] == 2'b11);
  assign inst_valid_o = head32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);
  assign inst_comp_o  = inst_valid_o && !head32;
  assign inst_o       = !inst_valid_o ? 32'h0 :
                        head32 ? {hb_q[1], hb_q[0]} : {16'h0, hb_q[0]};
  assign inst_pc_o    = pc_q;
  assign fetch_addr_o = fetch_q;
  // Ready looks only at registered occupancy so memory never waits on decode.
  assign mem_ready_o  = rst_n && (cnt_q <= 3'd2);
  assign push         = mem_valid_i && mem_ready_o;
  assign pop          = inst_valid_o && inst_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    fetch_d = fetch_q;
    src     = 3'd0;
    for (int i = 0; i < 4; i++) begin
      hb_d[i] = hb_q[i];
    end

    pop_n  = pop  ? (head32 ? 3'd2 : 3'd1) : 3'd0;
    push_n = push ? ((state_q == RUN) ? 3'd2 : 3'd1) : 3'd0;
    surv   = cnt_q - pop_n;

    // Shift survivors down, then drop pushed halfwords right behind them.
    for (int i = 0; i < 4; i++) begin
      src = 3'(i) + pop_n;
      if (src <= 3'd3) begin
        hb_d[i] = hb_q[src[1:0]];
      end
      if (push && (3'(i) == surv)) begin
        hb_d[i] = (state_q == RUN) ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
      end
      if (push && (state_q == RUN) && (3'(i) == surv + 3'd1)) begin
        hb_d[i] = mem_rdata_i[31:16];
      end
    end

    cnt_d = cnt_q - pop_n + push_n;
    if (pop) begin
      pc_d = pc_q + (head32 ? 32'd4 : 32'd2);
    end
    if (push) begin
      fetch_d = fetch_q + 32'd4;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_PC[1] ? SKIP_HI : RUN;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC & ~32'h1;
      fetch_q <= RESET_PC & ~32'h3;
      for (int i = 0; i < 4; i++) begin
        hb_q[i] <= 16'h0;
      end
    end else if (flush_i) begin
      state_q <= flush_pc_i[1] ? SKIP_HI : RUN;
      cnt_q   <= 3'd0;
      pc_q    <= flush_pc_i & ~32'h1;
      fetch_q <= flush_pc_i & ~32'h3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      fetch_q <= fetch_d;
      for (int i = 0; i < 4; i++) begin
        hb_q[i] <= hb_d[i];
      end
    end
  end

endmodule

// File: tb/tb_c_fetch_align.sv
// tb/tb_c_fetch_align.sv - self-checking bench for c_fetch_align against a parcel queue model
module tb_c_fetch_align;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_comp_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  bit          m_skip;

  c_fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_addr_o (fetch_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_valid_i  (mem_valid_i),
    .mem_ready_o  (mem_ready_o),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_comp_o  (inst_comp_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (mq[0][1:0] == 2'b11) return mq.size() >= 2;
    return 1'b1;
  endfunction

  task automatic check_model();
    bit          vld;
    logic [31:0] ei;
    vld = m_valid();
    chk("model_mem_ready", {31'h0, mem_ready_o}, {31'h0, (rst_n && mq.size() <= 2)});
    chk("model_valid", {31'h0, inst_valid_o}, {31'h0, vld});
    chk("model_fetch", fetch_addr_o, m_fetch);
    chk("model_pc", inst_pc_o, m_pc);
    if (vld) begin
      if (mq[0][1:0] == 2'b11) ei = {mq[1], mq[0]};
      else ei = {16'h0, mq[0]};
      chk("model_inst", inst_o, ei);
      chk("model_comp", {31'h0, inst_comp_o}, {31'h0, (mq[0][1:0] != 2'b11)});
    end
  endtask

  task automatic model_update();
    bit vld;
    bit is32;
    bit acc;
    if (!rst_n) begin
      mq.delete();
      m_pc    = RESET_PC & ~32'h1;
      m_fetch = RESET_PC & ~32'h3;
      m_skip  = RESET_PC[1];
    end else if (flush_i) begin
      mq.delete();
      m_pc    = flush_pc_i & ~32'h1;
      m_fetch = flush_pc_i & ~32'h3;
      m_skip  = flush_pc_i[1];
    end else begin
      vld  = m_valid();
      is32 = 1'b0;
      if (vld) is32 = (mq[0][1:0] == 2'b11);
      acc  = mem_valid_i && (mq.size() <= 2);
      if (vld && inst_ready_i) begin
        void'(mq.pop_front());
        if (is32) begin
          void'(mq.pop_front());
          m_pc = m_pc + 32'd4;
        end else begin
          m_pc = m_pc + 32'd2;
        end
      end
      if (acc) begin
        if (!m_skip) mq.push_back(mem_rdata_i[15:0]);
        mq.push_back(mem_rdata_i[31:16]);
        m_skip  = 1'b0;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit v, input logic [31:0] d, input bit r,
                     input bit f, input logic [31:0] fp);
    rst_n        = rn;
    mem_valid_i  = v;
    mem_rdata_i  = d;
    inst_ready_i = r;
    flush_i      = f;
    flush_pc_i   = fp;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] drain_inst [4];
    rst_n = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
    inst_ready_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    mq.delete(); m_pc = '0; m_fetch = '0; m_skip = 1'b0;

    // reset values
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h4501_4505, 1, 0, 0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_ready", {31'h0, mem_ready_o}, 32'h0);
    chk("rst_comp", {31'h0, inst_comp_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h8000_0000);
    chk("rst_fetch", fetch_addr_o, 32'h8000_0000);

    // compressed pair
    cyc(1, 1, 32'h4501_4505, 0, 0, 0);
    chk("pair_inst0", inst_o, 32'h0000_4505);
    chk("pair_pc0", inst_pc_o, 32'h8000_0000);
    chk("pair_comp0", {31'h0, inst_comp_o}, 32'h1);
    chk("pair_fetch", fetch_addr_o, 32'h8000_0004);
    cyc(1, 0, 0, 1, 0, 0);
    chk("pair_inst1", inst_o, 32'h0000_4501);
    chk("pair_pc1", inst_pc_o, 32'h8000_0002);
    cyc(1, 0, 0, 1, 0, 0);
    chk("pair_empty", {31'h0, inst_valid_o}, 32'h0);

    // spanning 32-bit instruction
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h0513_0001, 0, 0, 0);
    chk("span_inst0", inst_o, 32'h0000_0001);
    chk("span_pc0", inst_pc_o, 32'h8000_0000);
    cyc(1, 1, 32'h0000_0000, 1, 0, 0);
    chk("span_inst1", inst_o, 32'h0000_0513);
    chk("span_comp1", {31'h0, inst_comp_o}, 32'h0);
    chk("span_pc1", inst_pc_o, 32'h8000_0002);
    cyc(1, 0, 0, 1, 0, 0);
    chk("zero_hw_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("zero_hw_inst", inst_o, 32'h0);
    chk("zero_hw_comp", {31'h0, inst_comp_o}, 32'h1);
    cyc(1, 0, 0, 1, 0, 0);

    // backpressure
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h4501_4505, 0, 0, 0);
    cyc(1, 1, 32'h4511_4515, 0, 0, 0);
    cyc(1, 1, 32'hdead_beef, 0, 0, 0);
    cyc(1, 1, 32'hcafe_f00d, 0, 0, 0);
    chk("bp_ready", {31'h0, mem_ready_o}, 32'h0);
    chk("bp_fetch", fetch_addr_o, 32'h8000_0008);
    chk("bp_hold", inst_o, 32'h0000_4505);
    drain_inst = '{32'h4505, 32'h4501, 32'h4515, 32'h4511};
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_inst", inst_o, drain_inst[i]);
      chk("bp_drain_pc", inst_pc_o, 32'h8000_0000 + 32'(2 * i));
      cyc(1, 0, 0, 1, 0, 0);
    end

    // halfword flush with concurrent push and pop
    cyc(1, 1, 32'h4501_4505, 0, 0, 0);
    cyc(1, 1, 32'h4511_4515, 1, 1, 32'h8000_0106);
    chk("flush_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("flush_fetch", fetch_addr_o, 32'h8000_0104);
    cyc(1, 1, 32'h1234_0001, 1, 0, 0);
    chk("flush_inst", inst_o, 32'h0000_1234);
    chk("flush_pc", inst_pc_o, 32'h8000_0106);
    cyc(1, 0, 0, 1, 0, 0);
    chk("flush_single", {31'h0, inst_valid_o}, 32'h0);

    // reset mid-stream with three halfwords buffered
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h4501_4505, 0, 0, 0);
    cyc(1, 1, 32'h4511_4515, 1, 0, 0);
    chk("mid_pc", inst_pc_o, 32'h8000_0002);
    cyc(0, 1, 32'h1111_1111, 1, 1, 32'h0000_0040);
    chk("mid_rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("mid_rst_fetch", fetch_addr_o, 32'h8000_0000);
    chk("mid_rst_pc", inst_pc_o, 32'h8000_0000);
    cyc(1, 1, 32'h1234_0001, 0, 0, 0);
    chk("mid_first_inst", inst_o, 32'h0000_0001);
    chk("mid_first_pc", inst_pc_o, 32'h8000_0000);

    // random streams
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) != 0,
          ($urandom % 10) < 7,
          $urandom,
          ($urandom % 10) < 6,
          ($urandom % 30) == 0,
          32'h8000_0000 + ($urandom & 32'hFFF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
